// File: rtl/serial_framer_if.sv
// Load handshake and serial-stream signals of the serial framer.
// The upstream side drives words in; the framer side drives the bit stream out.
interface serial_framer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             serialOutput;
   logic             bit_valid;
   logic             bit_last;
   logic             busy;

   modport master (
      output data_in, load_valid,
      input  load_ready, serialOutput, bit_valid, bit_last, busy
   );

   modport slave (
      input  data_in, load_valid,
      output load_ready, serialOutput, bit_valid, bit_last, busy
   );
endinterface

// File: rtl/serial_framer.sv
// Parallel-to-serial framer: one word shifting plus one word held behind it,
// one bit per clock, with an optional idle gap after each word.
module serial_framer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input logic            clk,
   input logic            reset,
   serial_framer_if.slave io
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sh, sh_nx;
   logic [WIDTH-1:0] hold, hold_nx;
   logic             hold_full, hold_full_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [3:0]       gcnt, gcnt_nx;
   logic             accept;
   logic             word_done;
   logic             head_nx;

   logic ser_q, bv_q, bl_q, busy_q, rdy_q;

   assign accept  = io.load_valid && !hold_full;
   assign head_nx = MSB_FIRST ? sh_nx[WIDTH-1] : sh_nx[0];

   // Next-state: hold fills on any non-idle accept; word boundaries pick hold, bypass or idle.
   always_comb begin
      state_nx     = state;
      sh_nx        = sh;
      hold_nx      = hold;
      hold_full_nx = hold_full;
      cnt_nx       = cnt;
      gcnt_nx      = gcnt;
      word_done    = 1'b0;

      if (accept && state != S_IDLE) begin
         hold_nx      = io.data_in;
         hold_full_nx = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (accept) begin
               sh_nx    = io.data_in;
               cnt_nx   = '0;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sh_nx  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
            cnt_nx = cnt + CW'(1);
            if (cnt == LAST) begin
               if (GAP_CYCLES > 0) begin
                  state_nx = S_GAP;
                  gcnt_nx  = 4'(GAP_CYCLES - 1);
               end else begin
                  word_done = 1'b1;
               end
            end
         end
         S_GAP: begin
            gcnt_nx = gcnt - 4'd1;
            if (gcnt == 4'd0) word_done = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase

      // A word just finished: a held word has priority over a same-edge offer.
      if (word_done) begin
         cnt_nx  = '0;
         gcnt_nx = '0;
         if (hold_full) begin
            sh_nx        = hold;
            hold_full_nx = 1'b0;
            state_nx     = S_SHIFT;
         end else if (accept) begin
            sh_nx        = io.data_in;
            hold_full_nx = 1'b0;
            state_nx     = S_SHIFT;
         end else begin
            state_nx = S_IDLE;
         end
      end
   end

   // State and outputs; outputs are registered images of the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         sh        <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
         gcnt      <= '0;
         ser_q     <= IDLE_LEVEL;
         bv_q      <= 1'b0;
         bl_q      <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         state     <= state_nx;
         sh        <= sh_nx;
         hold      <= hold_nx;
         hold_full <= hold_full_nx;
         cnt       <= cnt_nx;
         gcnt      <= gcnt_nx;
         ser_q     <= (state_nx == S_SHIFT) ? head_nx : IDLE_LEVEL;
         bv_q      <= (state_nx == S_SHIFT);
         bl_q      <= (state_nx == S_SHIFT) && (cnt_nx == LAST);
         busy_q    <= (state_nx != S_IDLE) || hold_full_nx;
         rdy_q     <= !hold_full_nx;
      end
   end

   assign io.serialOutput = ser_q;
   assign io.bit_valid    = bv_q;
   assign io.bit_last     = bl_q;
   assign io.busy         = busy_q;
   assign io.load_ready   = rdy_q;
endmodule
